// File: rtl/layer6_pool_pkg.sv
// rtl/layer6_pool_pkg.sv - shared state type and parameter defaults for the layer-6 pool scheduler
package layer6_pool_pkg;

  localparam int OUT_WIDTH_DEF = 8;
  localparam int ADDR_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/pool_scan_counter.sv
// rtl/pool_scan_counter.sv - row-major 2-D scan counter with clear, advance and last-position flag
module pool_scan_counter #(
  parameter int              ADDR_W = 16,
  parameter logic [ADDR_W-1:0] MAX  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] row,
  output logic [ADDR_W-1:0] col,
  output logic              last
);

  // col runs 0..MAX then wraps and bumps row; clear wins over advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col == MAX) begin
        col <= '0;
        row <= (row == MAX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  assign last = (row == MAX) && (col == MAX);

endmodule

// File: rtl/layer6_pool_scheduler.sv
// rtl/layer6_pool_scheduler.sv - read/capture/save sequencer for the layer-6 2x2 max-pooling datapath
module layer6_pool_scheduler
  import layer6_pool_pkg::*;
#(
  parameter int OUT_WIDTH = OUT_WIDTH_DEF,
  parameter int ADDR_W    = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              out_ready,
  output logic              read_pixel_signal,
  output logic [ADDR_W-1:0] read_row_addr,
  output logic [ADDR_W-1:0] read_col_addr,
  output logic              pool_reg_en,
  output logic              save_enable,
  output logic [ADDR_W-1:0] output_row,
  output logic [ADDR_W-1:0] output_col,
  output logic              busy,
  output logic              pipeline_first_done,
  output logic              layer_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(OUT_WIDTH - 1);

  state_t state, state_nxt;

  logic              s1_valid, s2_valid;
  logic [ADDR_W-1:0] s1_row, s1_col, s2_row, s2_col;
  logic              stall, accept, scan_clear, scan_last;
  logic              s2_is_first, s2_is_last;

  assign stall       = s2_valid & ~out_ready;
  assign accept      = s2_valid & out_ready;
  assign scan_clear  = (state == IDLE) & start;
  assign s2_is_first = (s2_row == '0) && (s2_col == '0);
  assign s2_is_last  = (s2_row == LAST) && (s2_col == LAST);

  assign read_pixel_signal   = (state == RUN) & ~stall;
  assign pool_reg_en         = s1_valid & ~stall;
  assign save_enable         = s2_valid;
  assign output_row          = s2_row;
  assign output_col          = s2_col;
  assign busy                = (state != IDLE);
  assign pipeline_first_done = accept & s2_is_first;
  assign layer_done          = accept & s2_is_last;

  pool_scan_counter #(
    .ADDR_W (ADDR_W),
    .MAX    (LAST)
  ) u_scan (
    .clk     (clk),
    .rst     (rst),
    .clear   (scan_clear),
    .advance (read_pixel_signal),
    .row     (read_row_addr),
    .col     (read_col_addr),
    .last    (scan_last)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next state: scan until the last read issues, then drain until the last save is taken
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (read_pixel_signal && scan_last) state_nxt = DRAIN;
      DRAIN:   if (accept && s2_is_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // two-stage in-flight tracking: s1 = buffer read pending, s2 = capture valid; frozen on stall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_row   <= '0;
      s1_col   <= '0;
      s2_valid <= 1'b0;
      s2_row   <= '0;
      s2_col   <= '0;
    end else if (!stall) begin
      s1_valid <= read_pixel_signal;
      s1_row   <= read_row_addr;
      s1_col   <= read_col_addr;
      s2_valid <= s1_valid;
      s2_row   <= s1_row;
      s2_col   <= s1_col;
    end
  end

endmodule
